// File: rtl/video_fetch_pkg.sv
// Shared video definitions: column counts, fetch FSM encoding and the
// 16-bit video memory address layout {screen, column, line}.
package video_fetch_pkg;

  localparam int COLS_NORM = 48;
  localparam int COLS_WIDE = 64;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_ABORT = 2'd2;

  localparam int ADDR_LINE_LSB = 0;
  localparam int ADDR_COL_LSB  = 8;
  localparam int ADDR_SCR_LSB  = 14;

  function automatic logic [15:0] pack_addr(input logic [1:0] scr,
                                            input logic [5:0] col,
                                            input logic [7:0] line);
    pack_addr = (16'(scr)  << ADDR_SCR_LSB) |
                (16'(col)  << ADDR_COL_LSB) |
                (16'(line) << ADDR_LINE_LSB);
  endfunction

endpackage

// File: rtl/video_line_ram.sv
// Simple dual-port 128x32 line RAM: synchronous write, registered read,
// address {bank, column}. No reset on the array or read register so it maps to block RAM.
module video_line_ram (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [6:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [128];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/video_fetch.sv
// Ping-pong line prefetch: on each line end, swap banks and fetch the next line over req/ack.
// Optional VIDEO_FETCH_UNDERRUN_EN adds a saturating underrun counter and sticky o_underrun.
//
// state    | meaning
// ST_IDLE  | no request outstanding, waiting for a line end
// ST_REQ   | requesting column col_q of the fill line
// ST_ABORT | underrun: hold the stale request until acked, drop its data
module video_fetch
  import video_fetch_pkg::*;
#(
  parameter int COLS_NORM = video_fetch_pkg::COLS_NORM,
  parameter int COLS_WIDE = video_fetch_pkg::COLS_WIDE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_line_end,
  input  logic [7:0]  i_line_idx,
  input  logic [5:0]  i_column,
  input  logic        i_wide_screen,
  input  logic [1:0]  i_screen,
  output logic [31:0] o_vdata,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data
`ifdef VIDEO_FETCH_UNDERRUN_EN
  , output logic      o_underrun
`endif
);

  fetch_state_t state_q, state_d;
  logic [5:0]   col_q, col_d;
  logic [7:0]   line_q, line_d;
  logic [1:0]   scr_q, scr_d;
  logic         wide_q, wide_d;
  logic [7:0]   nxt_line_q, nxt_line_d;
  logic [1:0]   nxt_scr_q, nxt_scr_d;
  logic         nxt_wide_q, nxt_wide_d;
  logic         disp_bank_q, disp_bank_d;
  logic [1:0]   valid_q, valid_d;
  logic [1:0]   bank_wide_q, bank_wide_d;
  logic         blank_q, blank_d;
  logic         fill_bank;
  logic         last_col;
  logic         ram_we;
  logic [6:0]   cols_disp;
  logic [31:0]  ram_rdata;

  assign fill_bank = ~disp_bank_q;
  assign last_col  = (col_q == (wide_q ? 6'(COLS_WIDE - 1) : 6'(COLS_NORM - 1)));
  assign cols_disp = bank_wide_q[disp_bank_q] ? 7'(COLS_WIDE) : 7'(COLS_NORM);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    scr_d       = scr_q;
    wide_d      = wide_q;
    nxt_line_d  = nxt_line_q;
    nxt_scr_d   = nxt_scr_q;
    nxt_wide_d  = nxt_wide_q;
    disp_bank_d = disp_bank_q;
    valid_d     = valid_q;
    bank_wide_d = bank_wide_q;
    ram_we      = 1'b0;
    blank_d     = !valid_q[disp_bank_q] || ({1'b0, i_column} >= cols_disp);

    if (i_line_end) begin
      disp_bank_d              = ~disp_bank_q;
      valid_d[disp_bank_q]     = 1'b0;
      bank_wide_d[disp_bank_q] = i_wide_screen;
      nxt_line_d               = i_line_idx + 8'd1;
      nxt_scr_d                = i_screen;
      nxt_wide_d               = i_wide_screen;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_line_end) begin
          state_d = ST_REQ;
          col_d   = '0;
          line_d  = i_line_idx + 8'd1;
          scr_d   = i_screen;
          wide_d  = i_wide_screen;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          ram_we = 1'b1;
          col_d  = col_q + 6'd1;
        end
        if (i_mem_ack && last_col) begin
          valid_d[fill_bank] = 1'b1;
          state_d            = ST_IDLE;
        end
        if (i_line_end) begin
          if (i_mem_ack && last_col) begin
            state_d = ST_REQ;
            col_d   = '0;
            line_d  = i_line_idx + 8'd1;
            scr_d   = i_screen;
            wide_d  = i_wide_screen;
          end else begin
            // Every unfinished line counts as an underrun, even if this cycle also acked.
            state_d = ST_ABORT;
            col_d   = col_q;
          end
        end
      end
      ST_ABORT: begin
        if (i_mem_ack) begin
          state_d = ST_REQ;
          col_d   = '0;
          line_d  = i_line_end ? i_line_idx + 8'd1 : nxt_line_q;
          scr_d   = i_line_end ? i_screen : nxt_scr_q;
          wide_d  = i_line_end ? i_wide_screen : nxt_wide_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      line_q      <= '0;
      scr_q       <= '0;
      wide_q      <= 1'b0;
      nxt_line_q  <= '0;
      nxt_scr_q   <= '0;
      nxt_wide_q  <= 1'b0;
      disp_bank_q <= 1'b0;
      valid_q     <= '0;
      bank_wide_q <= '0;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      line_q      <= line_d;
      scr_q       <= scr_d;
      wide_q      <= wide_d;
      nxt_line_q  <= nxt_line_d;
      nxt_scr_q   <= nxt_scr_d;
      nxt_wide_q  <= nxt_wide_d;
      disp_bank_q <= disp_bank_d;
      valid_q     <= valid_d;
      bank_wide_q <= bank_wide_d;
      blank_q     <= blank_d;
    end
  end

  video_line_ram u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i ({fill_bank, col_q}),
    .wdata_i (i_mem_data),
    .raddr_i ({disp_bank_q, i_column}),
    .rdata_o (ram_rdata)
  );

  // RAM read data is unreset; the blank flag masks it until a valid bank is displayed.
  assign o_vdata    = blank_q ? 32'h0 : ram_rdata;
  assign o_mem_req  = (state_q != ST_IDLE);
  assign o_mem_addr = pack_addr(scr_q, col_q, line_q);

`ifdef VIDEO_FETCH_UNDERRUN_EN
  logic [15:0] underrun_cnt_q;
  logic        underrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_cnt_q <= '0;
      underrun_q     <= 1'b0;
    end else if (state_q == ST_REQ && state_d == ST_ABORT) begin
      underrun_q <= 1'b1;
      if (underrun_cnt_q != 16'hFFFF) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
    end
  end

  assign o_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch: request addresses and column reads are
// predicted from a line-level model and checked by a monitor as the DUT presents them.
`timescale 1ns/1ps
module tb_video_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_line_end = 1'b0;
  logic [7:0]  i_line_idx = '0;
  logic [5:0]  i_column = '0;
  logic        i_wide_screen = 1'b0;
  logic [1:0]  i_screen = '0;
  logic [31:0] o_vdata;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data;
`ifdef VIDEO_FETCH_UNDERRUN_EN
  logic        o_underrun;
`endif

  int checks = 0;
  int errors = 0;

  video_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line_end(i_line_end),
    .i_line_idx(i_line_idx), .i_column(i_column), .i_wide_screen(i_wide_screen),
    .i_screen(i_screen), .o_vdata(o_vdata), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
`ifdef VIDEO_FETCH_UNDERRUN_EN
    , .o_underrun(o_underrun)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return {a ^ 16'hC3A5, a + 16'h1357};
  endfunction

  assign i_mem_data = mem_fn(o_mem_addr);

  // line-level model: the line being fetched and the line on screen
  logic [15:0] addr_q[$];
  logic [31:0] rd_q[$];
  int cur_line = 0, cur_scr = 0, cur_wide = 0;
  bit cur_valid = 0;
  int disp_line = 0, disp_scr = 0, disp_wide = 0;
  bit disp_ok = 0;

  function automatic int ncols(input int wide);
    return (wide != 0) ? 64 : 48;
  endfunction

  function automatic logic [31:0] exp_word(input int col);
    if (!disp_ok || col >= ncols(disp_wide)) return 32'h0;
    return mem_fn(16'(disp_scr * 16384 + col * 256 + disp_line));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // memory responder: ack_period 0 = random, N = every Nth requested cycle
  int ack_period = 1;
  bit ack_hold = 0;
  int ack_ctr = 0;
  always @(posedge i_clk) begin
    #1;
    if (!o_mem_req || ack_hold) begin
      i_mem_ack = 1'b0;
    end else if (ack_period == 0) begin
      i_mem_ack = ($urandom_range(0, 1) == 1);
    end else begin
      ack_ctr++;
      if (ack_ctr >= ack_period) begin
        i_mem_ack = 1'b1;
        ack_ctr = 0;
      end else begin
        i_mem_ack = 1'b0;
      end
    end
  end

  // monitor
  int acks_seen = 0;
  bit prev_pend = 0;
  logic [15:0] prev_addr = '0;
  logic rd_issue = 1'b0;
  logic rd_v = 1'b0;
  always @(posedge i_clk) rd_v <= rd_issue;

  always @(negedge i_clk) begin
    if (i_rst_n && o_mem_req) begin
      if (prev_pend) chk("addr_hold", 32'(o_mem_addr), 32'(prev_addr));
      if (i_mem_ack) begin
        acks_seen++;
        if (addr_q.size() == 0) begin
          chk("unexpected_req", 32'(o_mem_addr), 32'hFFFF_FFFF);
        end else begin
          chk("mem_addr", 32'(o_mem_addr), 32'(addr_q.pop_front()));
        end
      end
      prev_pend = !i_mem_ack;
      prev_addr = o_mem_addr;
    end else begin
      prev_pend = 0;
    end
    if (rd_v) begin
      if (rd_q.size() == 0) chk("unexpected_read", o_vdata, 32'hDEAD_BEEF);
      else chk("vdata", o_vdata, rd_q.pop_front());
    end
  end

  task automatic issue_le(input int l, input int scr, input int wide,
                          input bit prev_done, input bit trim);
    i_line_idx    = 8'(l);
    i_screen      = 2'(scr);
    i_wide_screen = 1'(wide);
    i_line_end    = 1'b1;
    disp_line = cur_line; disp_scr = cur_scr; disp_wide = cur_wide;
    disp_ok   = cur_valid && prev_done;
    cur_line  = (l + 1) % 256; cur_scr = scr; cur_wide = wide; cur_valid = 1;
    if (trim) while (addr_q.size() > 1) void'(addr_q.pop_back());
    for (int c = 0; c < ncols(wide); c++)
      addr_q.push_back(16'(scr * 16384 + c * 256 + cur_line));
    @(posedge i_clk); #1;
    i_line_end = 1'b0;
  endtask

  task automatic line_end(input int l, input int scr, input int wide);
    @(posedge i_clk); #1;
    issue_le(l, scr, wide, 1, 0);
  endtask

  task automatic read_col(input int c);
    @(posedge i_clk); #1;
    i_column = 6'(c);
    rd_issue = 1'b1;
    rd_q.push_back(exp_word(c));
  endtask

  task automatic read_end();
    @(posedge i_clk); #1;
    rd_issue = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge i_clk); #2;
      if (!o_mem_req && addr_q.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL fetch_done actual=busy(%0d left) required=idle", addr_q.size());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int base;
  bit found;

  initial begin
    #12;
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_vdata", o_vdata, 32'd0);
`ifdef VIDEO_FETCH_UNDERRUN_EN
    chk("rst_underrun", 32'(o_underrun), 32'd0);
`endif
    @(negedge i_clk); i_rst_n = 1'b1;

    // ack always high, L=10 wide screen 2; first displayed line is black
    ack_period = 1;
    line_end(10, 2, 1);
    read_col(5); read_end();
    wait_done(500);
    line_end(11, 2, 1);
    read_col(5); read_col(0); read_col(63); read_end();
    wait_done(500);

    // ack every 3rd cycle, normal width
    ack_period = 3;
    line_end(20, 1, 0);
    read_col(12); read_end();
    wait_done(1000);
    line_end(21, 1, 0);
    for (int c = 0; c < 48; c++) read_col(c);
    read_col(50); read_col(63); read_end();
    wait_done(1000);

    // line 255 wraps to 0
    ack_period = 1;
    line_end(255, 0, 1);
    wait_done(500);
    line_end(0, 3, 1);
    read_col(7); read_col(63); read_end();
    wait_done(500);

    // underrun at column 20
    ack_period = 3; ack_hold = 0;
    base = acks_seen;
    line_end(40, 0, 1);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge i_clk);
      if (acks_seen - base >= 20) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL abort_setup actual=%0d acks required=20", acks_seen - base);
    end
    ack_hold = 1;
    @(posedge i_clk); #1;
    issue_le(41, 3, 0, 0, 1);
    ack_hold = 0;
    read_col(0); read_col(5); read_col(20); read_end();
`ifdef VIDEO_FETCH_UNDERRUN_EN
    chk("underrun_flag", 32'(o_underrun), 32'd1);
    chk("underrun_cnt", 32'(dut.underrun_cnt_q), 32'd1);
`endif
    wait_done(1000);
    line_end(42, 1, 1);
    read_col(0); read_col(20); read_col(47); read_col(48); read_end();
    wait_done(1000);

    // line end coincident with the final ack
    ack_period = 1;
    line_end(50, 2, 0);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge i_clk); #2;
      if (o_mem_req && i_mem_ack && o_mem_addr[13:8] == 6'd47) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL last_ack actual=not_seen required=col47_ack");
    end
    issue_le(60, 1, 1, 1, 0);
    read_col(0); read_col(47); read_col(48); read_end();
    wait_done(500);
    line_end(61, 0, 0);
    read_col(3); read_col(63); read_end();
    wait_done(500);

    // randomized lines and reads with random ack timing
    ack_period = 0;
    for (int it = 0; it < 6; it++) begin
      line_end($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 1));
      for (int k = 0; k < 8; k++) read_col($urandom_range(0, 63));
      read_col(ncols(disp_wide) - 1);
      if (ncols(disp_wide) < 64) read_col(ncols(disp_wide));
      read_end();
      wait_done(2000);
    end

    // reset mid-fetch
    line_end(100, 1, 1);
    repeat (10) @(posedge i_clk);
    @(negedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(o_mem_req), 32'd0);
    chk("midrst_addr", 32'(o_mem_addr), 32'd0);
    chk("midrst_vdata", o_vdata, 32'd0);
`ifdef VIDEO_FETCH_UNDERRUN_EN
    chk("midrst_underrun", 32'(o_underrun), 32'd0);
`endif
    addr_q.delete();
    cur_valid = 0; disp_ok = 0;
    @(negedge i_clk); i_rst_n = 1'b1;
    line_end(5, 0, 0);
    read_col(0); read_col(10); read_end();
    wait_done(2000);
    line_end(6, 0, 0);
    read_col(0); read_col(10); read_end();
    wait_done(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
